axi_lite_req_arbiter: RTL and testbench
=======================================

Name: axi_lite_req_arbiter

Overview:
- Shares the single AXI4-Lite master user interface among NUM_REQ independent requesters, one transaction at a time.
- Per-requester ports on one side; the other side connects directly to the master's start/write-enable/addr/wdata/rdata/done user port.
- Grants round-robin, latches the winner's command, issues a one-cycle start, and waits for done.
- Routes completion and read data back to the winner only.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester request; held high with fields stable until req_ready
- req_we  in  NUM_REQ  per-requester 1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data; same packing as req_addr
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: command issued to master
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transaction complete
- rsp_rdata  out  DATA_W  read data, valid while rsp_valid is high; held afterwards
- m_start  out  1  to master start input
- m_write_en  out  1  to master write enable
- m_addr  out  ADDR_W  to master address
- m_wdata  out  DATA_W  to master write data
- m_rdata  in  DATA_W  from master read data
- m_done  in  1  from master one-cycle done pulse
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE, grant 0, rr pointer NUM_REQ-1 (requester 0 wins first).
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata, busy.
- All outputs are registered.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Latch grant index, req_we, addr and wdata into m_write_en/m_addr/m_wdata; set pointer = grant; go to ISSUE.
  - If no req_valid bit is set, stay in IDLE.
- ISSUE (exactly one cycle): m_start=1 and req_ready[grant]=1 in the same cycle; go to WAIT.
- WAIT:
  - m_start=0; m_addr, m_wdata and m_write_en stay held.
  - On m_done: next cycle rsp_valid[grant]=1; rsp_rdata=m_rdata for reads, 0 for writes; go to IDLE.
- Latency:
  - req_valid sampled in IDLE at cycle N gives m_start and req_ready at N+1.
  - m_done at cycle M gives rsp_valid at M+1.
  - Back-to-back grant: next m_start no earlier than M+2, which is compatible with the master's done-then-idle sequencing.
- m_done outside WAIT is ignored.
- At most one transaction is outstanding; other requesters stall with req_valid held.
- req_valid dropping before req_ready is a protocol violation: not checked, and the latched command still issues.
- Rotation with all requesters continuously valid: 0,1,2,3,0,... Requester 3 alone after grant 3 is re-granted 3.
- Reset mid-operation:
  - Returns to IDLE immediately and discards any pending response.
  - The master shares rst, so no transaction survives reset.

Optional Feature:
- Macro: AXI_ARB_PRIO0_EN.
- Defined: requester 0 is strict high priority. It wins in IDLE whenever req_valid[0]=1. Otherwise round-robin among 1..NUM_REQ-1, and a grant of 0 does not move the pointer.
- Undefined: pure round-robin over all requesters as above.

Decomposition:
- Package axi_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - default width localparams (ADDR_W/DATA_W = 32)
- Sub-module rr_pick: combinational, parameter N.
  - Inputs: req vector and pointer.
  - Outputs: any flag and winner index.
  - Instantiated once in axi_lite_req_arbiter.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles, busy=0.
- Single read: req_valid[2]=1, we=0, addr=0x40 → m_start pulse one cycle later with m_addr=0x40, m_write_en=0, req_ready=4'b0100. Model m_done after 5 cycles with m_rdata=0xDEADBEEF → rsp_valid=4'b0100 next cycle, rsp_rdata=0xDEADBEEF.
- Single write: req_valid[1]=1, we=1, addr=0x10, wdata=0x1234 → m_write_en=1, m_wdata=0x1234; on done, rsp_valid=4'b0010, rsp_rdata=0.
- Fairness: all four req_valid held continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3, exactly one m_start per m_done.
- Robustness:
  - Reset asserted in WAIT → state IDLE next cycle, no rsp_valid issued.
  - m_done pulsed while IDLE → ignored, no rsp_valid.
- AXI_ARB_PRIO0_EN defined: req 0 and req 2 held continuously → 0 is granted every time and 2 never while 0 is valid. After 0 drops, 2 is granted.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// ============================================================================
// Module      : axi_arb_pkg
// Description : Shared state encoding and default widths for the AXI4-Lite
//               request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_arb_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_lite_req_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request bit
//               searching upward from ptr+1, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int N       = 4,
    localparam int c_IDX_W = $clog2(N)
) (
    input  logic [N-1:0]       i_req,
    input  logic [c_IDX_W-1:0] i_ptr,
    output logic               o_any,
    output logic [c_IDX_W-1:0] o_idx
);

    int w_cand;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        for (int i = N; i >= 1; i--) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = c_IDX_W'(w_cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_lite_req_arbiter.sv
// ============================================================================
// Module      : axi_lite_req_arbiter
// Description : Round-robin arbiter sharing one AXI4-Lite master user port
//               among NUM_REQ requesters, one transaction at a time.
//               Optional macro AXI_ARB_PRIO0_EN makes requester 0 strict
//               high priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_req_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DATA_W  = c_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      m_start,
    output logic                      m_write_en,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_done,
    output logic                      busy
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    arb_state_t          r_state,      w_state_nxt;
    logic [c_IDX_W-1:0]  r_grant,      w_grant_nxt;
    logic [c_IDX_W-1:0]  r_ptr,        w_ptr_nxt;
    logic [NUM_REQ-1:0]  r_req_ready,  w_req_ready_nxt;
    logic [NUM_REQ-1:0]  r_rsp_valid,  w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata,  w_rsp_rdata_nxt;
    logic                r_m_start,    w_m_start_nxt;
    logic                r_m_write_en, w_m_write_en_nxt;
    logic [ADDR_W-1:0]   r_m_addr,     w_m_addr_nxt;
    logic [DATA_W-1:0]   r_m_wdata,    w_m_wdata_nxt;
    logic                r_busy,       w_busy_nxt;

    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  w_pick_req;
    logic                w_any;
    logic [c_IDX_W-1:0]  w_win;
    logic                w_sel_any;
    logic [c_IDX_W-1:0]  w_sel_idx;
    logic                w_sel_move;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

`ifdef AXI_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation; the picker only sees 1..NUM_REQ-1.
    assign w_pick_req = {req_valid[NUM_REQ-1:1], 1'b0};
    assign w_sel_any  = req_valid[0] | w_any;
    assign w_sel_idx  = req_valid[0] ? '0 : w_win;
    assign w_sel_move = ~req_valid[0];
`else
    assign w_pick_req = req_valid;
    assign w_sel_any  = w_any;
    assign w_sel_idx  = w_win;
    assign w_sel_move = 1'b1;
`endif

    rr_pick #(
        .N     (NUM_REQ)
    ) u_rr_pick (
        .i_req (w_pick_req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_win)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_ptr_nxt        = r_ptr;
        w_req_ready_nxt  = '0;
        w_rsp_valid_nxt  = '0;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_m_start_nxt    = 1'b0;
        w_m_write_en_nxt = r_m_write_en;
        w_m_addr_nxt     = r_m_addr;
        w_m_wdata_nxt    = r_m_wdata;

        case (r_state)
            IDLE: begin
                if (w_sel_any) begin
                    w_grant_nxt                = w_sel_idx;
                    w_ptr_nxt                  = w_sel_move ? w_sel_idx : r_ptr;
                    w_m_write_en_nxt           = req_we[w_sel_idx];
                    w_m_addr_nxt               = w_addr_arr[w_sel_idx];
                    w_m_wdata_nxt              = w_wdata_arr[w_sel_idx];
                    w_m_start_nxt              = 1'b1;
                    w_req_ready_nxt[w_sel_idx] = 1'b1;
                    w_state_nxt                = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    w_rsp_valid_nxt[r_grant] = 1'b1;
                    w_rsp_rdata_nxt          = r_m_write_en ? '0 : m_rdata;
                    w_state_nxt              = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_ptr        <= c_IDX_W'(NUM_REQ - 1);
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_m_start    <= 1'b0;
            r_m_write_en <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_ptr        <= w_ptr_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_m_start    <= w_m_start_nxt;
            r_m_write_en <= w_m_write_en_nxt;
            r_m_addr     <= w_m_addr_nxt;
            r_m_wdata    <= w_m_wdata_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign m_start    = r_m_start;
    assign m_write_en = r_m_write_en;
    assign m_addr     = r_m_addr;
    assign m_wdata    = r_m_wdata;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_req_arbiter.sv
// ============================================================================
// Module      : tb_axi_lite_req_arbiter
// Description : Scoreboard testbench for axi_lite_req_arbiter with a simple
//               master model. Honours AXI_ARB_PRIO0_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_lite_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_we = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      m_start;
    logic                      m_write_en;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [DATA_W-1:0]         m_rdata = '0;
    logic                      m_done = 1'b0;
    logic                      busy;

    always #5 clk = ~clk;

    axi_lite_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .m_start    (m_start),
        .m_write_en (m_write_en),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_done     (m_done),
        .busy       (busy)
    );

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
    } cmd_t;

    typedef struct {
        logic [3:0]  onehot;
        logic [31:0] rdata;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program a requester's fields and queue the expected command and response.
    task automatic push_txn(input int idx, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] mrd);
        cmd_t       c;
        rsp_t       r;
        logic [3:0] oh;
        req_we[idx]                   = we;
        req_addr[idx*ADDR_W +: ADDR_W] = addr;
        req_wdata[idx*DATA_W +: DATA_W] = wdata;
        c.idx = idx; c.we = we; c.addr = addr; c.wdata = wdata; c.mrd = mrd;
        oh = 4'b0001 << idx;
        r.onehot = oh;
        r.rdata  = we ? 32'h0 : mrd;
        cmd_q.push_back(c);
        rsp_q.push_back(r);
    endtask

    task automatic push_std(input int idx);
        push_txn(idx, idx[0], 32'h100 * (idx + 1), 32'h1000 + idx, 32'hC0DE_0000 + idx);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Master model: accept the issued command, answer after delay cycles.
    task automatic run_txn(input bit drop, input int delay);
        cmd_t c;
        rsp_t r;
        bit   ok;
        int   extra;
        wait_start(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL start_timeout: m_start=%b after 50 cycles, required 1", m_start);
            if (cmd_q.size() > 0) void'(cmd_q.pop_front());
            if (rsp_q.size() > 0) void'(rsp_q.pop_front());
            return;
        end
        c = cmd_q.pop_front();
        r = rsp_q.pop_front();
        n_checks++;
        if (req_ready !== r.onehot || m_write_en !== c.we || m_addr !== c.addr ||
            m_wdata !== c.wdata || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_cmd: got ready=%b we=%b addr=%h wdata=%h busy=%b, required ready=%b we=%b addr=%h wdata=%h busy=1",
                     req_ready, m_write_en, m_addr, m_wdata, busy, r.onehot, c.we, c.addr, c.wdata);
        end
        if (drop) req_valid[c.idx] = 1'b0;
        extra = 0;
        for (int i = 0; i < delay; i++) begin
            step();
            if (m_start !== 1'b0 || req_ready !== '0) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL start_pulse: %0d extra start/ready cycles during WAIT, required 0", extra);
        end
        m_done  = 1'b1;
        m_rdata = c.mrd;
        step();
        m_done  = 1'b0;
        m_rdata = 32'h5555_AAAA;
        n_checks++;
        if (rsp_valid !== r.onehot || rsp_rdata !== r.rdata || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL response: got rsp_valid=%b rdata=%h busy=%b, required rsp_valid=%b rdata=%h busy=0",
                     rsp_valid, rsp_rdata, busy, r.onehot, r.rdata);
        end
    endtask

    task automatic check_latency(input logic [3:0] exp_ready);
        step();
        n_checks++;
        if (m_start !== 1'b1 || req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL start_latency: got m_start=%b ready=%b, required 1 %b", m_start, req_ready, exp_ready);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({req_ready, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d ready=%b rsp=%b rdata=%h start=%b we=%b addr=%h wdata=%h busy=%b, required all 0",
                         i, req_ready, rsp_valid, rsp_rdata, m_start, m_write_en, m_addr, m_wdata, busy);
            end
            step();
        end
    endtask

    task automatic test_single_read();
        push_txn(2, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
        req_valid = 4'b0100;
        check_latency(4'b0100);
        run_txn(1'b1, 5);
        step();
        n_checks++;
        if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_hold: got rsp_valid=%b rdata=%h, required 0000 deadbeef", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_single_write();
        push_txn(1, 1'b1, 32'h10, 32'h1234, 32'hBAD0_BAD0);
        req_valid = 4'b0010;
        check_latency(4'b0010);
        run_txn(1'b1, 5);
    endtask

    task automatic test_fairness();
        int         seq [8];
        logic [3:0] mask;
`ifdef AXI_ARB_PRIO0_EN
        seq  = '{1, 2, 3, 1, 2, 3, 1, 2};
        mask = 4'b1110;
`else
        seq  = '{0, 1, 2, 3, 0, 1, 2, 3};
        mask = 4'b1111;
`endif
        pulse_reset();
        for (int k = 0; k < 8; k++) push_std(seq[k]);
        req_valid = mask;
        for (int k = 0; k < 8; k++) begin
            run_txn(1'b0, 3);
            if (k < 7) begin
                step();
                n_checks++;
                if (m_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL back_to_back: txn %0d got m_start=%b two cycles after done, required 1", k, m_start);
                end
            end
        end
        // Requester 3 alone right after its own grant is granted again.
        push_std(3);
        req_valid = 4'b1000;
        run_txn(1'b1, 2);
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        push_std(3);
        void'(cmd_q.pop_back());
        void'(rsp_q.pop_back());
        req_valid = 4'b1000;
        wait_start(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_wait_start: m_start=%b after 50 cycles, required 1", m_start);
        end
        req_valid = '0;
        repeat (2) step();
        rst    = 1'b1;
        m_done = 1'b1;
        step();
        rst    = 1'b0;
        m_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || m_start !== 1'b0 || m_addr !== '0) begin
            n_fail++;
            $display("FAIL rst_in_wait: got busy=%b rsp=%b start=%b addr=%h, required 0 0000 0 0", busy, rsp_valid, m_start, m_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_rsp: cycle %0d got rsp=%b busy=%b, required 0000 0", i, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_done_in_idle();
        m_done  = 1'b1;
        m_rdata = 32'hFACE_FACE;
        step();
        m_done  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rsp_valid !== '0 || busy !== 1'b0 || rsp_rdata === 32'hFACE_FACE) begin
                n_fail++;
                $display("FAIL done_in_idle: cycle %0d got rsp=%b busy=%b rdata=%h, required 0000 0 unchanged", i, rsp_valid, busy, rsp_rdata);
            end
            step();
        end
    endtask

    task automatic test_prio();
        pulse_reset();
`ifdef AXI_ARB_PRIO0_EN
        for (int k = 0; k < 3; k++) push_std(0);
        req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) run_txn(1'b0, 2);
        req_valid[0] = 1'b0;
        push_std(2);
        run_txn(1'b1, 2);
`else
        push_std(0); push_std(2); push_std(0); push_std(2);
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) run_txn(1'b0, 2);
        req_valid = '0;
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_reset_in_wait();
        test_done_in_idle();
        test_prio();
        n_checks++;
        if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d cmds %0d rsps left, required 0 0", cmd_q.size(), rsp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
